// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift/rotate unit with a start/done handshake.
// It covers logical, arithmetic and rotate shifts in both directions and
// moves at most STEP bit positions per clock.
// Optional feature macro: SEQ_SHIFTER_SAT_EN makes SSHL saturate and drives ovf.
// Without the macro, SSHL wraps like SHL and ovf is held at 0.
module seq_shifter #(
    parameter int DATAWIDTH  = 8,
    parameter int SHAMTWIDTH = 3,
    parameter int STEP       = 1
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        start,
    input  logic [2:0]                  mode,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic [SHAMTWIDTH-1:0]       sh_amt,
    output logic signed [DATAWIDTH-1:0] d,
    output logic                        busy,
    output logic                        done,
    output logic                        ovf
);

    localparam int CW = $clog2(DATAWIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_SHL   = 3'b000,
        OP_SSHL  = 3'b001,
        OP_SHR   = 3'b010,
        OP_SSHR  = 3'b011,
        OP_ROL   = 3'b100,
        OP_ROR   = 3'b101,
        OP_PASS0 = 3'b110,
        OP_PASS1 = 3'b111
    } op_e;

    state_e               state_q, state_d;
    op_e                  mode_q, mode_d;
    logic [DATAWIDTH-1:0] work_q, work_d;
    logic [DATAWIDTH-1:0] res_q, res_d;
    logic [DATAWIDTH-1:0] step_work;
    logic [CW-1:0]        rem_q, rem_d;
    logic [CW-1:0]        step_rem;
    logic [CW-1:0]        n_eff;
    logic [31:0]          amt_ext;
    logic [31:0]          n_wide;
`ifdef SEQ_SHIFTER_SAT_EN
    logic                 sign_q, sign_d;
    logic                 acc_q, acc_d;
    logic                 step_acc;
    logic                 ovf_q, ovf_d;
`endif

    // Effective shift amount: logical/arithmetic shifts clamp at the width, rotates wrap.
    always_comb begin
        amt_ext = 32'(sh_amt);
        n_wide  = '0;
        case (op_e'(mode))
            OP_SHL, OP_SSHL, OP_SHR, OP_SSHR:
                n_wide = (amt_ext > 32'(DATAWIDTH)) ? 32'(DATAWIDTH) : amt_ext;
            OP_ROL, OP_ROR:
                n_wide = amt_ext % 32'(DATAWIDTH);
            default:
                n_wide = '0;
        endcase
        n_eff = CW'(n_wide);
    end

    // One SHIFT step: move up to STEP single-bit positions, never past the remaining count.
    always_comb begin
        step_work = work_q;
`ifdef SEQ_SHIFTER_SAT_EN
        step_acc  = acc_q;
`endif
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(rem_q)) begin
                case (mode_q)
                    OP_SHL, OP_SSHL: begin
`ifdef SEQ_SHIFTER_SAT_EN
                        if (step_work[DATAWIDTH-1] != sign_q) begin
                            step_acc = 1'b1;
                        end
`endif
                        step_work = {step_work[DATAWIDTH-2:0], 1'b0};
                    end
                    OP_SHR:  step_work = {1'b0, step_work[DATAWIDTH-1:1]};
                    OP_SSHR: step_work = {step_work[DATAWIDTH-1], step_work[DATAWIDTH-1:1]};
                    OP_ROL:  step_work = {step_work[DATAWIDTH-2:0], step_work[DATAWIDTH-1]};
                    OP_ROR:  step_work = {step_work[0], step_work[DATAWIDTH-1:1]};
                    default: step_work = step_work;
                endcase
            end
        end
        step_rem = (rem_q > CW'(STEP)) ? (rem_q - CW'(STEP)) : '0;
    end

    // Next-state logic: capture in IDLE/DONE, step in SHIFT, load the result on entry to DONE.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        work_d  = work_q;
        rem_d   = rem_q;
        res_d   = res_q;
`ifdef SEQ_SHIFTER_SAT_EN
        sign_d  = sign_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mode_d  = op_e'(mode);
                    work_d  = a;
                    rem_d   = n_eff;
`ifdef SEQ_SHIFTER_SAT_EN
                    sign_d  = a[DATAWIDTH-1];
                    acc_d   = 1'b0;
`endif
                    state_d = (n_eff == '0) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = step_work;
                rem_d  = step_rem;
`ifdef SEQ_SHIFTER_SAT_EN
                acc_d  = step_acc;
`endif
                if (step_rem == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == DONE) begin
            res_d = work_d;
`ifdef SEQ_SHIFTER_SAT_EN
            ovf_d = 1'b0;
            if (mode_d == OP_SSHL && (acc_d || (work_d[DATAWIDTH-1] != sign_d))) begin
                ovf_d = 1'b1;
                res_d = sign_d ? {1'b1, {(DATAWIDTH-1){1'b0}}}
                               : {1'b0, {(DATAWIDTH-1){1'b1}}};
            end
`endif
        end
    end

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            mode_q  <= OP_SHL;
            work_q  <= '0;
            rem_q   <= '0;
            res_q   <= '0;
`ifdef SEQ_SHIFTER_SAT_EN
            sign_q  <= 1'b0;
            acc_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
`ifdef SEQ_SHIFTER_SAT_EN
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign d    = res_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
`ifdef SEQ_SHIFTER_SAT_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Multi-cycle, parametrised shift/rotate unit for the generated datapath. It supersedes the single-mode combinational shift components: one instance covers logical, arithmetic and rotate shifts in both directions. It trades latency for area by shifting at most STEP bits per clock, and uses a start/done handshake so the scheduler can issue it like any other multi-cycle component.

## Interface
- DATAWIDTH, 8: operand and result width in bits (≥2).
- SHAMTWIDTH, 3: width of sh_amt; may encode amounts ≥ DATAWIDTH.
- STEP, 1: maximum bits shifted per clock (1..DATAWIDTH).

Ports (clock and reset first):
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when idle or in DONE.
- mode  input  3  operation select: 000 SHL, 001 SSHL, 010 SHR, 011 SSHR, 100 ROL, 101 ROR, 110/111 pass-through.
- a  input  DATAWIDTH  signed operand.
- sh_amt  input  SHAMTWIDTH  unsigned shift amount.
- d  output  DATAWIDTH  signed result register; holds its value until the next done.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when d is updated.
- ovf  output  1  saturation flag, valid with done (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- In IDLE or DONE with start=1, the unit captures a, mode, and the effective amount n into internal registers.
- Effective amount n:
  - SHL, SSHL, SHR, SSHR: n = min(sh_amt, DATAWIDTH).
  - ROL, ROR: n = sh_amt mod DATAWIDTH.
  - Pass-through: n = 0.
- If n = 0, the next state is DONE. Otherwise it is SHIFT.
- SHIFT: each clock shifts the work register by k = min(STEP, remaining) and decrements remaining by k. When remaining reaches 0, the next state is DONE.
- Fill rules:
  - SHL and SSHL fill with zeros from the LSB.
  - SHR fills with zeros from the MSB.
  - SSHR replicates the captured sign bit.
  - ROL and ROR wrap bits around.
- Consequences: n = DATAWIDTH gives 0 for logical modes and all-sign for SSHR.
- DONE (one cycle): d ← work register, done = 1, ovf updated. Next state is IDLE, or a new capture if start=1.
- start while busy is ignored. Inputs a, mode and sh_amt may change freely after capture.
- Reset outputs: d = 0, busy = 0, done = 0, ovf = 0. Internal registers are also cleared.
- Rst asserted mid-operation aborts immediately. No done pulse is produced for the aborted request.

## Timing
- Latency from the start-sampling edge to the done-high cycle is ceil(n/STEP)+1 clocks; n = 0 gives 1 clock.
- Maximum latency is ceil(DATAWIDTH/STEP)+1.
- Back-to-back throughput: a start sampled during DONE begins the next request with no idle cycle.
- busy rises in the cycle after start is accepted (only when n > 0) and falls when the unit enters DONE.
- d, done and ovf are registered outputs; there are no combinational paths from inputs to outputs.

## Configuration
- Macro SEQ_SHIFTER_SAT_EN.
- Defined:
  - SSHL saturates. If any bit shifted out, or the final MSB, differs from the sign of the captured a, then d = maximum positive value (a ≥ 0) or minimum negative value (a < 0), and ovf = 1 with done.
  - Overflow detection is tracked incrementally on each SHIFT step.
- Not defined:
  - SSHL behaves identically to SHL (wraps).
  - ovf is tied to 0.
  - No saturation logic is synthesised.

## Test plan
- DATAWIDTH=8, STEP=1, SSHR, a=8'h90 (−112), sh_amt=3 -> d=8'hF2 (−14); done 4 clocks after start; busy high for 3 cycles.
- SHAMTWIDTH=4, ROL, a=8'h81, sh_amt=9 -> n=1, d=8'h03, done 2 clocks after start. Same setup with SHR, sh_amt=12 -> d=8'h00.
- STEP=4, SHL, a=8'h0F, sh_amt=7 -> d=8'h80; done 3 clocks after start. A second start asserted in the DONE cycle is accepted without a gap.
- SSHL, a=8'h30, sh_amt=2 -> with SEQ_SHIFTER_SAT_EN: d=8'h7F, ovf=1. Without the macro: d=8'hC0, ovf=0. Also a=8'hF0, sh_amt=3 -> d=8'h80, ovf=0 in both builds.
- Pass-through mode 110, or sh_amt=0, with a=8'h5A -> done 1 clock after start, d=8'h5A, busy never asserted.
- Start SHR with sh_amt=6, then pulse Rst low in the 3rd SHIFT cycle -> d, busy, done and ovf are 0 immediately. No done pulse follows. A start during busy in an unreset run is ignored, and d reflects only the first request.
